// File: rtl/rom_stream_ctrl.sv
// Read sequencer: walks the ROM filter region then the ifmap region, absorbing the
// ROM's 1-cycle read latency in a 2-entry skid FIFO feeding a valid/ready stream.
module rom_stream_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FILT_BASE  = 49,
  parameter int unsigned FILT_LEN   = 9,
  parameter int unsigned IFMAP_BASE = 0,
  parameter int unsigned IFMAP_LEN  = 49
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  rom_read,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_dout,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_is_filt,
  output logic                  out_last
);

  typedef enum logic [2:0] {IDLE, FILT, IFMAP, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] FILT_BASE_A  = ADDR_WIDTH'(FILT_BASE);
  localparam logic [ADDR_WIDTH-1:0] IFMAP_BASE_A = ADDR_WIDTH'(IFMAP_BASE);
  localparam logic [ADDR_WIDTH-1:0] FILT_LAST    = ADDR_WIDTH'(FILT_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] IFMAP_LAST   = ADDR_WIDTH'(IFMAP_LEN - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    inflight_q, tag_filt_q, tag_last_q;
  logic [DATA_WIDTH-1:0]   data_q [2];
  logic [1:0]              filt_q, last_q;
  logic                    rd_ptr_q, wr_ptr_q;
  logic [1:0]              count_q;
  logic                    pop, push, room;

  assign out_valid   = (count_q != 2'd0);
  assign pop         = out_valid & out_ready;
  assign push        = inflight_q;
  assign out_data    = data_q[rd_ptr_q];
  assign out_is_filt = filt_q[rd_ptr_q];
  assign out_last    = last_q[rd_ptr_q];
  assign rom_addr    = addr_q;

  // Words already owed to the FIFO (stored + in flight), less the one leaving now, must stay below 2.
  assign room = ({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    idx_d    = idx_q;
    rom_read = 1'b0;
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILT;
          addr_d  = FILT_BASE_A;
          idx_d   = '0;
        end
      end
      FILT: begin
        if (room) begin
          rom_read = 1'b1;
          if (idx_q == FILT_LAST) begin
            state_d = IFMAP;
            addr_d  = IFMAP_BASE_A;
            idx_d   = '0;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            idx_d  = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      IFMAP: begin
        if (room) begin
          rom_read = 1'b1;
          if (idx_q == IFMAP_LAST) begin
            state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            idx_d  = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        // The final word is the only one left once it is at the head with nothing behind it.
        if (pop && out_last && (count_q == 2'd1) && !inflight_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
      tag_filt_q <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      idx_q      <= idx_d;
      inflight_q <= rom_read;
      tag_filt_q <= (state_q == FILT);
      tag_last_q <= (state_q == IFMAP) && (idx_q == IFMAP_LAST);
    end
  end

  // rom_dout is only looked at when a read was issued last cycle; the ROM floats otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      filt_q    <= '0;
      last_q    <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= rom_dout;
        filt_q[wr_ptr_q] <= tag_filt_q;
        last_q[wr_ptr_q] <= tag_last_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Bench for rom_stream_ctrl: addr-as-data ROM model, randomized consumer, reference
// word ordering built directly from the region layout.
module tb_rom_stream_ctrl;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int FB = 49;
  localparam int FL = 9;
  localparam int IB = 0;
  localparam int IL = 49;
  localparam int NW = FL + IL;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, rom_read, out_valid, out_is_filt, out_last;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] out_data;
  wire  [DW-1:0] rom_dout;
  logic rom_vld = 1'b0;
  logic [DW-1:0] rom_q = '0;

  logic start2 = 1'b0;
  logic ready2 = 1'b0;
  logic busy2, done2, rom_read2, valid2, filt2, last2;
  logic [AW-1:0] rom_addr2;
  logic [DW-1:0] data2;
  wire  [DW-1:0] rom_dout2;
  logic rom_vld2 = 1'b0;
  logic [DW-1:0] rom_q2 = '0;

  int checks = 0;
  int failures = 0;
  word_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_vld  <= rom_read;
    if (rom_read) rom_q <= {{(DW-AW){1'b0}}, rom_addr};
    rom_vld2 <= rom_read2;
    if (rom_read2) rom_q2 <= {{(DW-AW){1'b0}}, rom_addr2};
  end
  assign rom_dout  = rom_vld  ? rom_q  : 'z;
  assign rom_dout2 = rom_vld2 ? rom_q2 : 'z;

  rom_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rom_read(rom_read), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_filt(out_is_filt), .out_last(out_last)
  );

  rom_stream_ctrl #(.FILT_LEN(1), .IFMAP_LEN(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .rom_read(rom_read2), .rom_addr(rom_addr2), .rom_dout(rom_dout2),
    .out_data(data2), .out_valid(valid2), .out_ready(ready2),
    .out_is_filt(filt2), .out_last(last2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_ref();
    word_t w;
    exp_q.delete();
    for (int k = 0; k < NW; k++) begin
      if (k < FL) begin
        w.d = DW'(FB + k); w.f = 1'b1; w.l = 1'b0;
      end else begin
        w.d = DW'(IB + k - FL); w.f = 1'b0; w.l = (k == NW - 1);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd"}, rom_read, 0);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_filt"}, out_is_filt, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  // pct: out_ready probability; stall_word: words popped before a 5-cycle stall (-1 none);
  // timing: check exact cycle numbers; pulse: pulse start at cycles 5/40; rst_word: reset point (-1 none)
  task automatic run_seq(input int pct, input int stall_word, input bit timing,
                         input bit pulse, input int rst_word);
    int cyc, widx, issued, popped, ndone, stall_left, stall_idx, occ;
    bit stalled, fin, p, stall_now;
    word_t w;
    build_ref();
    chk("idle_before_start", busy, 0);
    @(negedge clk); start = 1'b1; out_ready = 1'b0;
    @(negedge clk); start = 1'b0;
    cyc = 1; widx = 0; issued = 0; popped = 0; ndone = 0;
    stall_left = 0; stall_idx = 0; stalled = 1'b0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      start = pulse && (cyc == 5 || cyc == 40);
      stall_now = 1'b0;
      if (stall_word >= 0 && !stalled && out_valid && widx == stall_word) begin
        stalled = 1'b1; stall_left = 5; stall_idx = 0;
      end
      if (stall_left > 0) begin
        out_ready = 1'b0; stall_left--; stall_idx++; stall_now = 1'b1;
      end else begin
        out_ready = ($urandom_range(99) < pct);
      end
      #1;
      if (rst_word >= 0 && widx == rst_word) begin
        chk("rst_read_in_flight", rom_vld, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_now");
        @(negedge clk);
        chk_all_zero("rst_held");
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk); #1;
        chk("rst_after_busy", busy, 0);
        chk("rst_after_done", done, 0);
        chk("rst_after_valid", out_valid, 0);
        @(negedge clk);
        return;
      end
      p = out_valid && out_ready;
      occ = issued - popped - int'(p) + int'(rom_read);
      chk("occupancy_le2", occ <= 2, 1);
      if (stall_now && stall_idx >= 2) chk("stall_no_read", rom_read, 0);
      if (out_valid) chk("no_x_data", $isunknown(out_data), 0);
      if (timing) begin
        chk("t_valid", out_valid, (cyc >= 3 && cyc <= 60));
        chk("t_done", done, (cyc == 61));
        chk("t_busy", busy, 1);
        if (cyc == 1) begin
          chk("t_c1_read", rom_read, 1);
          chk("t_c1_addr", rom_addr, FB);
        end
      end
      if (p) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("word_data", out_data, w.d);
          chk("word_filt", out_is_filt, w.f);
          chk("word_last", out_last, w.l);
        end
        widx++;
        popped++;
      end
      if (rom_read) issued++;
      if (done) begin
        ndone++;
        chk("done_after_all_words", widx, NW);
        @(negedge clk); out_ready = 1'b0; #1;
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("one_done", ndone, 1);
    chk("issued_reads", issued, NW);
    chk("words_remaining", exp_q.size(), 0);
  endtask

  initial begin
    int n, nw, nd2, last_pop, done_cyc;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_v_valid", valid2, 0);
    chk("reset_v_busy", busy2, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(100, -1, 1'b1, 1'b0, -1);
    run_seq(100, 19, 1'b0, 1'b0, -1);
    for (int s = 0; s < 10; s++) run_seq(50, -1, 1'b0, 1'b0, -1);
    run_seq(50, -1, 1'b0, 1'b1, -1);

    // start held high: back-to-back sequences with one idle cycle between them
    @(negedge clk); start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 63; c++) begin
      @(negedge clk); #1;
      if (c == 61) chk("hold_done61", done, 1);
      if (c == 62) chk("hold_idle62", busy, 0);
      if (c == 63) chk("hold_busy63", busy, 1);
    end
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("hold_second_done", done, 1);
    @(negedge clk);

    run_seq(100, -1, 1'b0, 1'b0, 29);
    run_seq(100, -1, 1'b1, 1'b0, -1);

    // FILT_LEN=1, IFMAP_LEN=1 variant
    @(negedge clk); start2 = 1'b1; ready2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    nw = 0; nd2 = 0; last_pop = -1; done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (valid2 && ready2) begin
        if (nw == 0) begin
          chk("v_w0_data", data2, FB);
          chk("v_w0_filt", filt2, 1);
          chk("v_w0_last", last2, 0);
        end else if (nw == 1) begin
          chk("v_w1_data", data2, IB);
          chk("v_w1_filt", filt2, 0);
          chk("v_w1_last", last2, 1);
        end else chk("v_extra_word", 1, 0);
        nw++;
        last_pop = c;
      end
      if (done2) begin
        nd2++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    chk("v_words", nw, 2);
    chk("v_one_done", nd2, 1);
    chk("v_done_after_pop", done_cyc, last_pop + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_stream_ctrl.md
# rom_stream_ctrl

Read sequencer between the 16-bit synchronous operand ROM and the PE-array input bus. On `start` it walks the ROM's filter region (3×3, 9 words), then its ifmap region (7×7, 49 words), issuing one read per cycle. It absorbs the ROM's 1-cycle read latency with a 2-entry skid FIFO and delivers words over a valid/ready stream, tagging each word with its region. It is the only master of the ROM's `read`/`addr` pins.

## Interface
- `DATA_WIDTH`, 16, ROM and stream word width
- `ADDR_WIDTH`, 6, ROM address width
- `FILT_BASE`, 49, first filter address
- `FILT_LEN`, 9, filter word count (≥1)
- `IFMAP_BASE`, 0, first ifmap address
- `IFMAP_LEN`, 49, ifmap word count (≥1)

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a sequence; sampled only in IDLE
- `busy`  out  1  high from the cycle after an accepted `start` through the `done` cycle
- `done`  out  1  one-cycle pulse after the final word is handshaked
- `rom_read`  out  1  ROM read enable
- `rom_addr`  out  ADDR_WIDTH  ROM address
- `rom_dout`  in  DATA_WIDTH  ROM data, valid the cycle after `rom_read`; otherwise Z/undefined
- `out_data`  out  DATA_WIDTH  stream word (FIFO head)
- `out_valid`  out  1  FIFO non-empty
- `out_ready`  in  1  consumer accepts when high with `out_valid`
- `out_is_filt`  out  1  head word belongs to the filter region
- `out_last`  out  1  head word is the final ifmap word

## Operation
- The FSM has five states: IDLE, FILT, IFMAP, DRAIN, DONE.
  - IDLE → FILT on `start`. The address counter loads FILT_BASE and the index loads 0.
  - FILT issues FILT_LEN reads at FILT_BASE+i. After the last filter issue, the address loads IFMAP_BASE and the FSM goes to IFMAP.
  - IFMAP issues IFMAP_LEN reads at IFMAP_BASE+i. After the last issue it goes to DRAIN.
  - DRAIN waits for the FIFO to be empty with nothing in flight and the final word handshaked, then goes to DONE.
  - DONE lasts one cycle (`done`=1) and returns to IDLE.
- Issue rule: `rom_read`=1 in FILT/IFMAP only when `count + inflight − pop < 2`.
  - `count` is FIFO occupancy (0–2).
  - `inflight` is a 1-bit register equal to last cycle's `rom_read`.
  - `pop` = `out_valid & out_ready`.
  - With `out_ready` held high, throughput is 1 word/cycle.
- Capture: when `inflight`=1, `rom_dout` is written into the FIFO at the edge. `rom_dout` is never sampled when `inflight`=0, because the ROM drives Z then.
- Tag bits `is_filt` and `last` are registered alongside `inflight` and stored with each FIFO entry.
- `rom_addr` holds its last value when `rom_read`=0. Its reset value is 0.
- Counters are ADDR_WIDTH wide and never wrap. The last issue of each region is detected by index == LEN−1.
- `start` is ignored while `busy`=1 or in DONE.
- `out_data`/`out_is_filt`/`out_last` show the FIFO head. They are don't-care while `out_valid`=0.
- Simultaneous push and pop on a full FIFO is legal and keeps `count`=2. The issue rule guarantees no push when full without a pop.
- The ROM's own `rst` pin is not driven by this block.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE.
  - All outputs are 0: `busy`, `done`, `rom_read`, `rom_addr`, `out_valid`, `out_data`, `out_is_filt`, `out_last`.
  - FIFO is empty, `inflight`=0.
- Reset asserted mid-sequence clears everything immediately. In-flight ROM data is discarded and no `done` is produced.
- Edges are numbered E1, E2, …; "cycle N" is the interval after edge EN.
- `start` is sampled high at edge E1:
  - cycle 1: `busy`=1, `rom_read`=1, `rom_addr`=FILT_BASE.
  - cycle 2: `rom_dout` is valid.
  - cycle 3: first word appears with `out_valid`=1. Start-to-first-word latency is 3 edges.
- With `out_ready`=1 throughout, words appear in cycles 3…60 (58 words).
  - `out_is_filt`=1 for cycles 3–11.
  - `out_last`=1 in cycle 60.
  - `done`=1 in cycle 61.
  - `busy`=0 from cycle 62.
- After `out_ready` drops, `rom_read` falls no later than the second cycle. No word is lost or duplicated. Streaming resumes 1 word/cycle the cycle `out_ready` returns.

## Test plan
- Basic stream, `out_ready`=1, ROM loaded with addr-as-data: 58 words in order 49..57, 0..48; first `out_valid` 3 cycles after `start`; `out_is_filt` on exactly the first 9 words; `out_last` only on data 48; single `done` in cycle 61.
- Backpressure: drop `out_ready` for 5 cycles starting at the 20th word. Check `count` ≤ 2, `rom_read`=0 while stalled, and the full 58-word sequence intact with no duplicates.
- Random `out_ready` (50%) over 10 sequences: words match the reference ordering, and `rom_dout` is never captured when `inflight`=0 (drive X/Z there and check that no X reaches `out_data` while `out_valid`=1).
- `start` pulsed during cycles 5 and 40 of a sequence: ignored, and exactly one `done`. `start` held high continuously starts back-to-back sequences with one IDLE cycle between `done` and the next `busy`.
- `rst_n` asserted at word 30 with a read in flight: all outputs are 0 immediately, FIFO empty. A fresh `start` then yields a clean 58-word stream.
- Parameter variant FILT_LEN=1, IFMAP_LEN=1: exactly 2 words; `out_is_filt`=1 on the first word; `out_last`=1 on the second; `done` follows the final handshake by 1 cycle.
